// File: rtl/hack_memory_ctrl.sv
// hack_memory_ctrl
// Memory-map controller between the Hack CPU data port and its storage.
// It decodes CPU accesses to general RAM, a dual-port screen buffer and a
// buffered keyboard with a status register, and gives a 1-cycle VGA read port.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   in, addr, load        CPU write data, word address, write strobe
//   rd_en                 CPU read request
//   out, out_valid        registered read data and its valid flag (1-cycle latency)
//   kbd_code, kbd_valid   key code from the keyboard decoder
//   kbd_ready             FIFO can accept a code (not full)
//   vga_word_addr         screen word address from the VGA scanner
//   vga_word, debug_led   registered screen word and its low byte
//   mem_err               sticky illegal-access flag
//
// Build option: define HACK_MEM_BOUNDS_EN to enable mem_err. Without it
// mem_err is tied low and all other behaviour is unchanged.
module hack_memory_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int KBD_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   in,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                load,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   out,
  output logic                out_valid,
  input  logic [DATA_W-1:0]   kbd_code,
  input  logic                kbd_valid,
  output logic                kbd_ready,
  input  logic [ADDR_W-3:0]   vga_word_addr,
  output logic [DATA_W-1:0]   vga_word,
  output logic [7:0]          debug_led,
  output logic                mem_err
);

  localparam int RAM_AW = ADDR_W - 1;
  localparam int SCR_AW = ADDR_W - 2;
  localparam int PW     = $clog2(KBD_DEPTH);
  localparam int CW     = PW + 1;

  // The keyboard registers sit at the bottom of the top quarter of the map.
  localparam logic [ADDR_W-1:0] KBD_DATA_ADDR = {2'b11, {(ADDR_W-2){1'b0}}};
  localparam logic [ADDR_W-1:0] KBD_STAT_ADDR = {2'b11, {(ADDR_W-3){1'b0}}, 1'b1};

  // Storage (contents are intentionally not reset)
  logic [DATA_W-1:0] ram_r  [0:(2**RAM_AW)-1];
  logic [DATA_W-1:0] scr_r  [0:(2**SCR_AW)-1];
  logic [DATA_W-1:0] fifo_r [0:KBD_DEPTH-1];

  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              ovf_r;
  logic [DATA_W-1:0] out_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] vga_word_r;

  logic              is_ram_s;
  logic              is_scr_s;
  logic              is_kdat_s;
  logic              is_kstat_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              stat_wr_s;
  logic [DATA_W-1:0] stat_s;
  logic [DATA_W-1:0] rd_data_s;

  assign is_ram_s   = (addr[ADDR_W-1] == 1'b0);
  assign is_scr_s   = (addr[ADDR_W-1:ADDR_W-2] == 2'b10);
  assign is_kdat_s  = (addr == KBD_DATA_ADDR);
  assign is_kstat_s = (addr == KBD_STAT_ADDR);

  assign full_s    = (count_r == CW'(KBD_DEPTH));
  assign empty_s   = (count_r == CW'(0));
  assign push_s    = kbd_valid && !full_s;
  // A pop on an empty FIFO is a no-op, so push+pop on empty pushes only.
  assign pop_s     = load && is_kdat_s && !empty_s;
  assign stat_wr_s = load && is_kstat_s;

  // Status word: overflow in the MSB, occupancy count in the low bits.
  always_comb begin
    stat_s           = {DATA_W{1'b0}};
    stat_s[DATA_W-1] = ovf_r;
    stat_s[CW-1:0]   = count_r;
  end

  // CPU read data mux, sampled from pre-write state (read-first).
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    if (is_ram_s) begin
      rd_data_s = ram_r[addr[RAM_AW-1:0]];
    end else if (is_scr_s) begin
      rd_data_s = scr_r[addr[SCR_AW-1:0]];
    end else if (is_kdat_s) begin
      if (!empty_s) begin
        rd_data_s = fifo_r[rd_ptr_r];
      end else begin
        rd_data_s = {DATA_W{1'b0}};
      end
    end else if (is_kstat_s) begin
      rd_data_s = stat_s;
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

  // RAM and screen write ports plus VGA screen read (old data on collision).
  always_ff @(posedge clock) begin
    if (load && is_ram_s) begin
      ram_r[addr[RAM_AW-1:0]] <= in;
    end
    if (load && is_scr_s) begin
      scr_r[addr[SCR_AW-1:0]] <= in;
    end
  end

  // Keyboard FIFO storage; stale entries are hidden by the pointers after reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= kbd_code;
    end
  end

  // Keyboard FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // A dropped code in the same cycle as a clear leaves overflow set.
      if (kbd_valid && full_s) begin
        ovf_r <= 1'b1;
      end else if (stat_wr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Registered CPU read data and valid; out holds when no read is issued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_r       <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= rd_en;
      if (rd_en) begin
        out_r <= rd_data_s;
      end
    end
  end

  // Registered VGA word, refreshed every cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_word_r <= {DATA_W{1'b0}};
    end else begin
      vga_word_r <= scr_r[vga_word_addr];
    end
  end

`ifdef HACK_MEM_BOUNDS_EN
  logic mem_err_r;
  logic unmapped_s;

  assign unmapped_s = !(is_ram_s || is_scr_s || is_kdat_s || is_kstat_s);

  // Sticky error: unmapped access or pop of an empty FIFO; cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_err_r <= 1'b0;
    end else if (((load || rd_en) && unmapped_s) || (load && is_kdat_s && empty_s)) begin
      mem_err_r <= 1'b1;
    end
  end

  assign mem_err = mem_err_r;
`else
  assign mem_err = 1'b0;
`endif

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign kbd_ready = !full_s;
  assign vga_word  = vga_word_r;
  assign debug_led = vga_word_r[7:0];

endmodule

// File: tb/tb_hack_memory_ctrl.sv
// Self-checking bench for hack_memory_ctrl (default parameters).
// A queue/array model tracks the memory map; a negedge process compares the
// DUT against it every cycle, and directed steps add literal expectations.
module tb_hack_memory_ctrl;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] in_s = 16'h0000;
  logic [14:0] addr_s = 15'h0000;
  logic        load_s = 1'b0;
  logic        rd_en_s = 1'b0;
  logic [15:0] out_s;
  logic        out_valid_s;
  logic [15:0] kbd_code_s = 16'h0000;
  logic        kbd_valid_s = 1'b0;
  logic        kbd_ready_s;
  logic [12:0] vga_addr_s = 13'h0000;
  logic [15:0] vga_word_s;
  logic [7:0]  debug_led_s;
  logic        mem_err_s;

  int checks = 0;
  int errors = 0;

  hack_memory_ctrl #(.DATA_W(16), .ADDR_W(15), .KBD_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .in(in_s), .addr(addr_s), .load(load_s),
    .rd_en(rd_en_s), .out(out_s), .out_valid(out_valid_s), .kbd_code(kbd_code_s),
    .kbd_valid(kbd_valid_s), .kbd_ready(kbd_ready_s), .vga_word_addr(vga_addr_s),
    .vga_word(vga_word_s), .debug_led(debug_led_s), .mem_err(mem_err_s)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [15:0] ram_m [0:16383];
  logic [15:0] scr_m [0:8191];
  bit          scr_known [0:8191];
  logic [15:0] fifo_q [$];
  logic        ovf_m;
  logic [15:0] out_m;
  logic        valid_m;
  logic [15:0] vga_m;
  bit          vga_known_m;
  logic        err_m;

  function automatic logic [15:0] model_read(input logic [14:0] a);
    if (a < 15'h4000) return ram_m[a[13:0]];
    if (a < 15'h6000) return scr_m[a[12:0]];
    if (a == 15'h6000) return (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
    if (a == 15'h6001) return (ovf_m ? 16'h8000 : 16'h0000) + 16'(fifo_q.size());
    return 16'h0000;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    int old_size;
    if (!reset_n) begin
      fifo_q.delete();
      ovf_m = 1'b0; out_m = 16'h0000; valid_m = 1'b0;
      vga_m = 16'h0000; vga_known_m = 1'b1; err_m = 1'b0;
    end else begin
      old_size = fifo_q.size();
      valid_m = rd_en_s;
      if (rd_en_s) out_m = model_read(addr_s);
      vga_m = scr_m[vga_addr_s];
      vga_known_m = scr_known[vga_addr_s];
`ifdef HACK_MEM_BOUNDS_EN
      if ((load_s || rd_en_s) && addr_s > 15'h6001) err_m = 1'b1;
      if (load_s && addr_s == 15'h6000 && old_size == 0) err_m = 1'b1;
`endif
      if (load_s) begin
        if (addr_s < 15'h4000) ram_m[addr_s[13:0]] = in_s;
        else if (addr_s < 15'h6000) begin
          scr_m[addr_s[12:0]] = in_s;
          scr_known[addr_s[12:0]] = 1'b1;
        end
        else if (addr_s == 15'h6000 && old_size > 0) void'(fifo_q.pop_front());
        else if (addr_s == 15'h6001) ovf_m = 1'b0;
      end
      if (kbd_valid_s) begin
        if (old_size < DEPTH) fifo_q.push_back(kbd_code_s);
        else ovf_m = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (reset_n) begin
      check("out_valid", {15'h0000, out_valid_s}, {15'h0000, valid_m});
      check("out", out_s, out_m);
      check("kbd_ready", {15'h0000, kbd_ready_s}, {15'h0000, (fifo_q.size() < DEPTH)});
      check("mem_err", {15'h0000, mem_err_s}, {15'h0000, err_m});
      if (vga_known_m) begin
        check("vga_word", vga_word_s, vga_m);
        check("debug_led", {8'h00, debug_led_s}, {8'h00, vga_m[7:0]});
      end
    end
  end

  // One CPU/keyboard cycle: drive inputs, return at the next negedge.
  task automatic cyc(input logic ld, input logic rd, input logic [14:0] a,
                     input logic [15:0] d, input logic kv, input logic [15:0] kc);
    load_s = ld; rd_en_s = rd; addr_s = a; in_s = d;
    kbd_valid_s = kv; kbd_code_s = kc;
    @(negedge clock);
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b0, a, d, 1'b0, 16'h0000);
  endtask

  task automatic rd_chk(input string name, input logic [14:0] a, input logic [15:0] exp);
    cyc(1'b0, 1'b1, a, 16'h0000, 1'b0, 16'h0000);
    check(name, out_s, exp);
  endtask

  task automatic push(input logic [15:0] kc);
    cyc(1'b0, 1'b0, 15'h0000, 16'h0000, 1'b1, kc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst out", out_s, 16'h0000);
    check("rst out_valid", {15'h0000, out_valid_s}, 16'h0000);
    check("rst kbd_ready", {15'h0000, kbd_ready_s}, 16'h0001);
    check("rst vga_word", vga_word_s, 16'h0000);
    check("rst mem_err", {15'h0000, mem_err_s}, 16'h0000);
    reset_n = 1'b1;

    // RAM write, read, read-first collision
    wr(15'h0010, 16'h1234);
    rd_chk("ram read", 15'h0010, 16'h1234);
    check("ram valid", {15'h0000, out_valid_s}, 16'h0001);
    cyc(1'b1, 1'b1, 15'h0010, 16'hBEEF, 1'b0, 16'h0000);
    check("read-first", out_s, 16'h1234);
    rd_chk("ram reread", 15'h0010, 16'hBEEF);
    cyc(1'b0, 1'b0, 15'h0000, 16'h0000, 1'b0, 16'h0000);
    check("valid drop", {15'h0000, out_valid_s}, 16'h0000);
    check("out hold", out_s, 16'hBEEF);

    // Screen and VGA port
    wr(15'h4000, 16'h00A5);
    cyc(1'b0, 1'b0, 15'h0000, 16'h0000, 1'b0, 16'h0000);
    check("vga word", vga_word_s, 16'h00A5);
    check("debug_led", {8'h00, debug_led_s}, 16'h00A5);
    rd_chk("scr read", 15'h4000, 16'h00A5);
    rd_chk("unmapped 6002", 15'h6002, 16'h0000);

    // Keyboard FIFO basics
    push(16'h0041); push(16'h0042); push(16'h0043);
    rd_chk("stat cnt3", 15'h6001, 16'h0003);
    rd_chk("head 41 a", 15'h6000, 16'h0041);
    rd_chk("head 41 b", 15'h6000, 16'h0041);
    wr(15'h6000, 16'hFFFF);
    rd_chk("head 42", 15'h6000, 16'h0042);
    wr(15'h6000, 16'h0000);
    wr(15'h6000, 16'h0000);
    rd_chk("stat empty", 15'h6001, 16'h0000);

    // Overflow and simultaneous push/pop
    push(16'h0051); push(16'h0052); push(16'h0053); push(16'h0054);
    check("ready full", {15'h0000, kbd_ready_s}, 16'h0000);
    push(16'h0055);
    rd_chk("stat ovf", 15'h6001, 16'h8004);
    wr(15'h6001, 16'h0000);
    rd_chk("stat clr", 15'h6001, 16'h0004);
    wr(15'h6000, 16'h0000);
    cyc(1'b1, 1'b0, 15'h6000, 16'h0000, 1'b1, 16'h0056);
    rd_chk("stat pushpop", 15'h6001, 16'h0003);
    rd_chk("head 53", 15'h6000, 16'h0053);

    // Reset mid-stream with two queued codes and a read pending
    wr(15'h6000, 16'h0000);
    rd_en_s = 1'b1; addr_s = 15'h0010; load_s = 1'b0; kbd_valid_s = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    check("mid rst out", out_s, 16'h0000);
    check("mid rst valid", {15'h0000, out_valid_s}, 16'h0000);
    check("mid rst ready", {15'h0000, kbd_ready_s}, 16'h0001);
    rd_en_s = 1'b0;
    reset_n = 1'b1;
    rd_chk("stat post rst", 15'h6001, 16'h0000);
    rd_chk("ram kept", 15'h0010, 16'hBEEF);

    // Push plus pop-write on an empty FIFO pushes only
    cyc(1'b1, 1'b0, 15'h6000, 16'h0000, 1'b1, 16'h0077);
    rd_chk("stat empty pp", 15'h6001, 16'h0001);
    rd_chk("head 77", 15'h6000, 16'h0077);

    // Unmapped accesses
    wr(15'h6002, 16'h1234);
    rd_chk("unmapped wr", 15'h6002, 16'h0000);
    rd_chk("unmapped 7fff", 15'h7FFF, 16'h0000);
`ifdef HACK_MEM_BOUNDS_EN
    check("mem_err set", {15'h0000, mem_err_s}, 16'h0001);
`else
    check("mem_err tied", {15'h0000, mem_err_s}, 16'h0000);
`endif
    repeat (3) cyc(1'b0, 1'b0, 15'h0000, 16'h0000, 1'b0, 16'h0000);
`ifdef HACK_MEM_BOUNDS_EN
    check("mem_err hold", {15'h0000, mem_err_s}, 16'h0001);
`else
    check("mem_err hold", {15'h0000, mem_err_s}, 16'h0000);
`endif
    reset_n = 1'b0;
    @(negedge clock);
    check("mem_err rst", {15'h0000, mem_err_s}, 16'h0000);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_memory_ctrl.md
Name: hack_memory_ctrl

Overview:
- Parametrised memory-map controller between the Hack CPU data port and its storage: general RAM, dual-port screen buffer, and a buffered keyboard.
- Adds registered reads with valid, a KBD_DEPTH-entry keyboard FIFO with ready/valid handshake, a status/acknowledge register pair, and a pipelined VGA read port.
- Sits between CPU and board I/O (VGA scanner, keyboard decoder, LEDs).

Parameters:
- DATA_W, 16, word width of every data path.
- ADDR_W, 15, CPU address width. Derived: RAM_AW = ADDR_W-1, SCR_AW = ADDR_W-2.
- KBD_DEPTH, 4, keyboard FIFO entries; power of two, >= 2.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- in  input  DATA_W  CPU write data.
- addr  input  ADDR_W  CPU word address.
- load  input  1  CPU write strobe.
- rd_en  input  1  CPU read request.
- out  output  DATA_W  registered read data.
- out_valid  output  1  out holds data for the rd_en of the previous cycle.
- kbd_code  input  DATA_W  key code from the keyboard decoder.
- kbd_valid  input  1  kbd_code valid.
- kbd_ready  output  1  FIFO can accept a code.
- vga_word_addr  input  SCR_AW  VGA read address.
- vga_word  output  DATA_W  registered screen word.
- debug_led  output  8  vga_word[7:0].
- mem_err  output  1  sticky illegal-access flag (see Optional Feature).

Behaviour:
- Address decode with default ADDR_W=15:
  - addr[ADDR_W-1]=0 → RAM, 0x0000–0x3FFF.
  - top bits 10 → SCREEN, 0x4000–0x5FFF.
  - KBD_DATA = 0x6000.
  - KBD_STAT = 0x6001.
  - Any other address in the 11 region is unmapped.
- Writes: when load=1, the write is committed at the rising edge.
  - RAM and SCREEN store `in`.
  - Write to KBD_DATA pops one FIFO entry; data is ignored; no effect if the FIFO is empty.
  - Write to KBD_STAT clears the overflow bit.
  - Writes to unmapped addresses are ignored.
- Reads: rd_en in cycle N → out and out_valid=1 in cycle N+1.
  - With rd_en=0, out_valid=0 next cycle and out holds its last value.
  - Read-first: a read and write to the same address in one cycle returns the old data.
  - KBD_DATA returns the FIFO head, or 0 if empty. Reading never pops.
  - KBD_STAT returns {overflow at bit DATA_W-1, zeros, count at bits [$clog2(KBD_DEPTH):0]}.
  - Unmapped addresses read 0.
- Keyboard FIFO:
  - kbd_ready = !full.
  - A push occurs when kbd_valid && kbd_ready.
  - kbd_valid while full drops the code and sets overflow (sticky).
  - A push and a pop in the same cycle both take effect; count is unchanged.
  - On an empty FIFO, a push plus a pop-write in the same cycle pushes only.
  - Pointers wrap modulo KBD_DEPTH.
- VGA port: vga_word is the SCREEN word at vga_word_addr from the previous cycle (1-cycle latency, every cycle, read-only). A CPU write to the same word in the same cycle returns the old data.
- Reset (async assert, sync release), values:
  - out=0, out_valid=0, vga_word=0.
  - FIFO empty, count=0, overflow=0, kbd_ready=1.
  - mem_err=0.
  - RAM and SCREEN contents are not reset.
- Reset mid-operation: FIFO contents are discarded. Pending reads produce no out_valid.

Optional Feature:
- Macro HACK_MEM_BOUNDS_EN.
- Defined:
  - Any load or rd_en to an unmapped address sets mem_err, which stays high until reset.
  - A pop-write to an empty FIFO also sets mem_err.
- Undefined: mem_err is tied 0; all other behaviour is identical.

Test Plan:
- Write 0x1234 to 0x0010, then rd_en 0x0010 → next cycle out=0x1234, out_valid=1. Same cycle as that read, write 0xBEEF to 0x0010 → out still 0x1234; re-read → 0xBEEF.
- CPU writes 0x00A5 to 0x4000; vga_word_addr=0 → vga_word=0x00A5 one cycle later, debug_led=0xA5. Read 0x6002 → 0.
- Push codes 0x41, 0x42, 0x43 → KBD_STAT reads count=3. KBD_DATA reads 0x41 twice (no pop). Write 0x6000 → KBD_DATA reads 0x42.
- Push 5 codes with KBD_DEPTH=4 → kbd_ready=0 after the 4th; KBD_STAT=0x8004. Write 0x6001 → 0x0004. Simultaneous push and pop at count 3 → count stays 3, head advances.
- Assert reset_n=0 mid-stream with 2 queued codes → out=0, out_valid=0, kbd_ready=1, KBD_STAT=0 after release; RAM word 0x0010 still reads back its last value.
- With HACK_MEM_BOUNDS_EN: rd_en at 0x7FFF → mem_err=1 and out=0; mem_err holds until reset. Without the macro: mem_err stays 0.
